// File: rtl/data_ram_pkg.sv
// data_ram_pkg: shared encodings, FSM states and counter width for data_ram_ctrl
package data_ram_pkg;
   localparam logic [2:0] T_B  = 3'b000;
   localparam logic [2:0] T_H  = 3'b001;
   localparam logic [2:0] T_W  = 3'b010;
   localparam logic [2:0] T_BU = 3'b100;
   localparam logic [2:0] T_HU = 3'b101;
   localparam int CNT_W = 4;
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
endpackage

// File: rtl/data_ram_ctrl_ram.sv
// ram_word_array: DEPTH_WORDS x 32 storage, byte-enable write, registered read, zero-initialised
module ram_word_array #(
   parameter int DEPTH_WORDS = 8192,
   parameter int IDX_W = $clog2(DEPTH_WORDS)
) (
   input  logic             clk,
   input  logic [3:0]       be,
   input  logic [IDX_W-1:0] addr,
   input  logic [31:0]      wdata,
   output logic [31:0]      rdata
);
   logic [31:0] mem [DEPTH_WORDS] = '{default: '0};
   // lane-masked write and read of the addressed word on every edge
   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      rdata <= mem[addr];
   end
endmodule

// File: rtl/data_ram_ctrl.sv
// data_ram_ctrl: single-port load/store RAM controller with wait states; DATA_RAM_MISALIGN_TRAP_EN faults misaligned H/W
module data_ram_ctrl
   import data_ram_pkg::*;
#(
   parameter int DEPTH_WORDS = 8192,
   parameter int ADDR_W = 32,
   parameter int WAIT_STATES = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_type,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err,
   output logic              rsp_wrote
);
   localparam int IDX_W = $clog2(DEPTH_WORDS);
   state_t state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic q_we;
   logic [2:0] q_type;
   logic [ADDR_W-1:0] q_addr;
   logic [31:0] q_wdata;
   logic idle, accept, commit, s_we, is_h, is_w, type_bad, range_bad, fault;
   logic [2:0] s_type;
   logic [ADDR_W-1:0] s_addr;
   logic [31:0] s_wdata, wd, rd, ld;
   logic [1:0] off;
   logic [3:0] be, ram_be;
   logic [7:0] b;
   logic [15:0] h;
   assign idle = state == IDLE;
   assign req_ready = idle;
   assign accept = req_valid && req_ready;
   // In IDLE the live request drives the RAM so a zero-wait access hits on the accept edge
   assign s_we = idle ? req_we : q_we;
   assign s_type = idle ? req_type : q_type;
   assign s_addr = idle ? req_addr : q_addr;
   assign s_wdata = idle ? req_wdata : q_wdata;
   assign is_h = s_type[1:0] == 2'b01;
   assign is_w = s_type[1:0] == 2'b10;
   assign type_bad = s_type == 3'b011 || s_type[2:1] == 2'b11 || (s_we && s_type[2]);
   assign range_bad = (s_addr >> (IDX_W + 2)) != '0;
`ifdef DATA_RAM_MISALIGN_TRAP_EN
   assign fault = type_bad || range_bad || (is_h && s_addr[0]) || (is_w && s_addr[1:0] != 2'b00);
   assign off = s_addr[1:0];
`else
   assign fault = type_bad || range_bad;
   assign off = is_w ? 2'b00 : is_h ? {s_addr[1], 1'b0} : s_addr[1:0];
`endif
   assign be = is_w ? 4'hf : is_h ? (off[1] ? 4'hc : 4'h3) : 4'(4'h1 << off);
   assign wd = s_wdata << {off, 3'b000};
   assign ram_be = (commit && !rst && s_we && !fault) ? be : 4'h0;
   assign b = 8'(rd >> {off, 3'b000});
   assign h = 16'(rd >> {off[1], 4'b0000});
   assign ld = s_type == T_B ? {{24{b[7]}}, b} : s_type == T_H ? {{16{h[15]}}, h} :
               s_type == T_BU ? {24'h0, b} : s_type == T_HU ? {16'h0, h} : rd;
   assign rsp_valid = state == RESP;
   assign rsp_err = rsp_valid && fault;
   assign rsp_wrote = rsp_valid && s_we && !fault;
   assign rsp_rdata = (rsp_valid && !fault && !s_we) ? ld : '0;
   ram_word_array #(.DEPTH_WORDS(DEPTH_WORDS), .IDX_W(IDX_W)) u_ram (
      .clk(clk),
      .be(ram_be),
      .addr(s_addr[2 +: IDX_W]),
      .wdata(wd),
      .rdata(rd)
   );
   // next state, wait countdown and the edge on which a store commits
   always_comb begin
      state_n = state;
      cnt_n = cnt;
      commit = 1'b0;
      case (state)
         IDLE: if (accept) begin
            state_n = WAIT_STATES > 0 ? WAIT : RESP;
            cnt_n = CNT_W'(WAIT_STATES == 0 ? 0 : WAIT_STATES - 1);
            commit = WAIT_STATES == 0;
         end
         WAIT: if (cnt == '0) begin
            state_n = RESP;
            commit = 1'b1;
         end else cnt_n = cnt - 1'b1;
         RESP: state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end
   // state register and request capture
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt <= '0;
         q_we <= 1'b0;
         q_type <= '0;
         q_addr <= '0;
         q_wdata <= '0;
      end else begin
         state <= state_n;
         cnt <= cnt_n;
         if (accept) begin
            q_we <= req_we;
            q_type <= req_type;
            q_addr <= req_addr;
            q_wdata <= req_wdata;
         end
      end
   end
endmodule

// File: tb/tb_data_ram_ctrl.sv
// tb_data_ram_ctrl: random + directed scoreboard bench for data_ram_ctrl at WAIT_STATES 0 and 3
module tb_data_ram_ctrl;
   localparam int DEPTH = 1024;
   localparam int NVEC = 400;
   localparam int ND = 16;
   typedef struct {int cyc; logic err; logic wrote; logic [31:0] rdata;} exp_t;
   logic clk = 0;
   int vectors = 0;
   int miscompares = 0;
   bit d_we [ND] = '{1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 0, 1};
   logic [2:0] d_type [ND] = '{3'd2, 3'd2, 3'd0, 3'd0, 3'd4, 3'd5, 3'd2, 3'd3,
                               3'd2, 3'd1, 3'd1, 3'd5, 3'd2, 3'd4, 3'd2, 3'd2};
   logic [31:0] d_addr [ND] = '{32'h10, 32'h10, 32'h13, 32'h13, 32'h13, 32'h12, 32'h1000, 32'h0,
                                32'h2, 32'h22, 32'h22, 32'h22, 32'h20, 32'h24, 32'hffc, 32'hfffffff0};
   logic [31:0] d_wdata [ND] = '{32'hdeadbeef, 0, 32'haaaaaa80, 0, 0, 0, 0, 0,
                                 0, 32'h55558001, 0, 0, 32'h12345678, 32'h1, 0, 32'h7};
   always #5 clk = ~clk;
   for (genvar g = 0; g < 2; g++) begin : u
      localparam int WS = g == 0 ? 0 : 3;
      logic rst = 1, req_valid = 0, req_we = 0;
      logic [2:0] req_type = 0;
      logic [31:0] req_addr = 0, req_wdata = 0;
      logic req_ready, rsp_valid, rsp_err, rsp_wrote;
      logic [31:0] rsp_rdata;
      exp_t q[$];
      logic [7:0] mem [DEPTH*4] = '{default: '0};
      int cyc = 0;
      bit done = 0;
      data_ram_ctrl #(.DEPTH_WORDS(DEPTH), .ADDR_W(32), .WAIT_STATES(WS)) dut (
         .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
         .req_we(req_we), .req_type(req_type), .req_addr(req_addr), .req_wdata(req_wdata),
         .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_wrote(rsp_wrote)
      );
      // byte-addressed memory model: legality, alignment, then byte copy and extension
      function automatic exp_t model(bit we, logic [2:0] t, logic [31:0] a, logic [31:0] wdat);
         exp_t e;
         int sz;
         bit legal, trap;
         logic [31:0] ea, v;
         sz = t[1:0] == 0 ? 1 : t[1:0] == 1 ? 2 : 4;
         legal = we ? (t <= 3'd2) : (t inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
         trap = 0;
`ifdef DATA_RAM_MISALIGN_TRAP_EN
         trap = (a % sz) != 0;
`endif
         ea = a - (a % sz);
         e.cyc = 0; e.err = 0; e.wrote = 0; e.rdata = 0;
         if (!legal || trap || a >= DEPTH * 4) e.err = 1;
         else if (we) begin
            for (int i = 0; i < sz; i++) mem[ea + i] = wdat[8*i +: 8];
            e.wrote = 1;
         end else begin
            v = 0;
            for (int i = 0; i < sz; i++) v = v | (32'(mem[ea + i]) << (8 * i));
            if (!t[2] && sz == 1 && v[7]) v = v | 32'hffffff00;
            if (!t[2] && sz == 2 && v[15]) v = v | 32'hffff0000;
            e.rdata = v;
         end
         return e;
      endfunction
      always @(posedge clk) cyc <= cyc + 1;
      initial begin
         int next_free, drop_at, n, d;
         exp_t e;
         logic [31:0] a;
         int s;
         repeat (3) @(negedge clk);
         rst = 0;
         next_free = 0; drop_at = -1; n = 0; d = 0;
         while (n < NVEC) begin
            if (rst) rst = 0;
            else begin
               vectors++;
               if (req_ready !== (cyc >= next_free)) begin
                  miscompares++;
                  $display("FAIL ready[%0d] cyc %0d: got %b want %b", WS, cyc, req_ready, cyc >= next_free);
               end
            end
            if (cyc == drop_at) begin
               rst = 1; req_valid = 0; next_free = cyc + 1; drop_at = -1;
            end else if (cyc >= next_free && !rst && !(d >= ND && $urandom_range(0, 3) == 0)) begin
               if (d < ND) begin
                  req_we = d_we[d]; req_type = d_type[d]; req_addr = d_addr[d]; req_wdata = d_wdata[d];
                  d++;
               end else begin
                  s = $urandom_range(0, 9);
                  a = s < 7 ? $urandom_range(0, 63) : s == 7 ? 32'(DEPTH * 4 - 8 + $urandom_range(0, 7)) :
                      s == 8 ? 32'(DEPTH * 4 + $urandom_range(0, 15)) : $urandom;
                  req_we = 1'($urandom_range(0, 1));
                  req_type = $urandom_range(0, 2) != 0 ? 3'($urandom_range(0, 5)) : 3'($urandom_range(0, 7));
                  if (req_type == 3'd3 && $urandom_range(0, 1) == 0) req_type = 3'd2;
                  req_addr = a; req_wdata = $urandom;
               end
               req_valid = 1;
               n++;
               next_free = cyc + WS + 2;
               if (WS > 0 && d >= ND && $urandom_range(0, 7) == 0) drop_at = cyc + $urandom_range(1, WS);
               else begin
                  e = model(req_we, req_type, req_addr, req_wdata);
                  e.cyc = cyc + 1 + WS;
                  q.push_back(e);
               end
            end else begin
               req_valid = (cyc >= next_free || rst) ? 1'b0 : 1'($urandom_range(0, 1));
               req_we = 1'($urandom_range(0, 1)); req_type = 3'($urandom_range(0, 7));
               req_addr = $urandom_range(0, 63); req_wdata = $urandom;
            end
            @(negedge clk);
         end
         req_valid = 0;
         done = 1;
      end
      // response monitor: pop and compare on every presented response, idle outputs must be zero
      always @(negedge clk) begin
         exp_t e;
         if (rsp_valid) begin
            vectors++;
            if (q.size() == 0) begin
               miscompares++;
               $display("FAIL rsp[%0d] unexpected at cyc %0d: err %b wrote %b rdata %h", WS, cyc, rsp_err, rsp_wrote, rsp_rdata);
            end else begin
               e = q.pop_front();
               if (e.cyc != cyc || e.err !== rsp_err || e.wrote !== rsp_wrote || e.rdata !== rsp_rdata) begin
                  miscompares++;
                  $display("FAIL rsp[%0d] got cyc %0d err %b wrote %b rdata %h, want cyc %0d err %b wrote %b rdata %h",
                           WS, cyc, rsp_err, rsp_wrote, rsp_rdata, e.cyc, e.err, e.wrote, e.rdata);
               end
            end
         end else if (!rst && (rsp_err || rsp_wrote || rsp_rdata != 0)) begin
            vectors++;
            miscompares++;
            $display("FAIL idle[%0d] cyc %0d: err %b wrote %b rdata %h, want all 0", WS, cyc, rsp_err, rsp_wrote, rsp_rdata);
         end
      end
   end
   initial begin
      int t;
      t = 0;
      while (!(u[0].done && u[1].done) && t < 20000) begin
         @(negedge clk);
         t++;
      end
      vectors++;
      if (t >= 20000) begin
         miscompares++;
         $display("FAIL timeout: drivers still running after %0d cycles, want completion", t);
      end
      repeat (8) @(negedge clk);
      vectors += 2;
      if (u[0].q.size() != 0) begin
         miscompares++;
         $display("FAIL drain[0]: %0d responses outstanding, want 0", u[0].q.size());
      end
      if (u[1].q.size() != 0) begin
         miscompares++;
         $display("FAIL drain[3]: %0d responses outstanding, want 0", u[1].q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
